// File: rtl/uart_tx.sv
// uart_tx: serial transmitter driven by an external baud strobe.
// Words enter through a valid/ready handshake into a one-entry holding
// register and leave LSB first as start / data / optional parity / stop
// frames. A held word starts on the tick that ends the previous stop bit,
// so queued frames follow each other with no idle gap.
module uart_tx #(
  parameter int data_bits = 8,  // 5..9
  parameter int stop_bits = 1,  // 1 or 2
  parameter int parity    = 0   // 0 none, 1 odd, 2 even
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic [data_bits-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(data_bits);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(stop_bits);
  localparam bit PARAMS_OK = (data_bits >= 5) && (data_bits <= 9) &&
                             (stop_bits >= 1) && (stop_bits <= 2) &&
                             (parity >= 0) && (parity <= 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [data_bits-1:0] d);
    logic p;
    p = ^d;
    if (parity == 1) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;        // data bits sent, or stop bits sent
  logic [data_bits-1:0]   r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_busy;
  logic [data_bits-1:0]   r_hold;
  logic                   r_hold_full;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [data_bits-1:0]   w_shift_nxt;
  logic                   w_par_nxt;
  logic                   w_tx_nxt;
  logic                   w_busy_nxt;
  logic                   w_load;       // holding register moves into the shifter
  logic                   w_accept;

  assign w_accept = i_valid && !r_hold_full;
  assign o_ready  = !r_hold_full;
  assign o_tx     = r_tx;
  assign o_busy   = r_busy;

  // Next-state and next-line-value logic; everything advances only on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_load      = 1'b0;
    if (i_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
            w_shift_nxt = r_hold;
            w_par_nxt   = parity_bit(r_hold);
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_tx_nxt    = 1'b1;
          end
        end
        S_START: begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[data_bits-1:1]};
          w_cnt_nxt   = CNT_W'(1);
        end
        S_DATA: begin
          if (r_cnt == DATA_LAST) begin
            if (parity != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
              w_cnt_nxt   = CNT_W'(1);
            end
          end else begin
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[data_bits-1:1]};
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end
        S_STOP: begin
          if (r_cnt == STOP_LAST) begin
            if (r_hold_full) begin
              // Zero-gap chaining: the held word's start bit replaces idle.
              w_load      = 1'b1;
              w_state_nxt = S_START;
              w_tx_nxt    = 1'b0;
              w_shift_nxt = r_hold;
              w_par_nxt   = parity_bit(r_hold);
              w_busy_nxt  = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
              w_tx_nxt    = 1'b1;
              w_busy_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_tx_nxt  = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      endcase
    end else begin
      w_load = 1'b0;
    end
  end

  // Shifter state, line and busy registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Holding register: fills on accept, empties when the shifter takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= i_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else begin
      r_hold_full <= r_hold_full;
    end
  end

  // Illegal parameter sets are a design error; trap them in simulation.
  always_ff @(posedge i_clk) begin
    assert (PARAMS_OK) else $error("uart_tx: illegal data_bits/stop_bits/parity");
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share
// clock, reset, tick and data; each gets its own i_valid.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] data;
  logic [3:0] valid;
  logic [3:0] tx;
  logic [3:0] ready;
  logic [3:0] busy;

  int checks   = 0;
  int failures = 0;
  int tick_per   = 0;
  int tick_phase = 0;
  int acc_cnt[4];
  logic cap_tx[4][0:127];
  logic cap_busy[4][0:127];

  always #5 clk = ~clk;

  uart_tx #(.data_bits(8), .stop_bits(1), .parity(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]));
  uart_tx #(.data_bits(8), .stop_bits(1), .parity(2)) u_even (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]));
  uart_tx #(.data_bits(8), .stop_bits(1), .parity(1)) u_odd (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]));
  uart_tx #(.data_bits(8), .stop_bits(2), .parity(0)) u_stop2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]));

  // Advance one clock; outputs are read and inputs set 1 ns after the edge.
  task automatic next_cyc();
    for (int w = 0; w < 4; w++) begin
      if (valid[w] && ready[w] && !rst) acc_cnt[w]++;
    end
    @(posedge clk);
    #1;
    if (tick_per == 0) begin
      tick = 1'b0;
    end else begin
      tick_phase = (tick_phase + 1) % tick_per;
      tick = (tick_phase == 0);
    end
  endtask

  // Record n cycles of line and busy for all instances.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 4; w++) begin
        cap_tx[w][i]   = tx[w];
        cap_busy[w][i] = busy[w];
      end
      next_cyc();
    end
  endtask

  // Wait (bounded) for instance w to drive a start bit.
  task automatic wait_start(input int w, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx[w] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      next_cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 4'hF; data = 8'hC3; tick_per = 1; tick = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      checks++; if (tx !== 4'hF) begin failures++; $display("FAIL rst_tx cyc%0d got=%b exp=1111", c, tx); end
      checks++; if (ready !== 4'hF) begin failures++; $display("FAIL rst_ready cyc%0d got=%b exp=1111", c, ready); end
      checks++; if (busy !== 4'h0) begin failures++; $display("FAIL rst_busy cyc%0d got=%b exp=0000", c, busy); end
    end
    valid = 4'h0;
    next_cyc();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cyc();
      checks++;
      if (tx !== 4'hF || busy !== 4'h0 || ready !== 4'hF) begin
        failures++; $display("FAIL post_rst_idle cyc%0d tx=%b busy=%b ready=%b exp=1111/0000/1111", c, tx, busy, ready);
      end
    end
  endtask

  task automatic test_frame_8n1();
    logic [9:0] exp_f;
    logic ok, bad, got;
    exp_f = 10'b1_10100101_0;  // stop, 0xA5, start
    tick_per = 4;
    data = 8'hA5; valid[0] = 1'b1;
    next_cyc();
    valid[0] = 1'b0;
    wait_start(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL a5_start_timeout got=none exp=start"); end
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL a5_ready_after_start got=%b exp=1", ready[0]); end
    capture(40);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0; got = exp_f[b];
      for (int k = 0; k < 4; k++) begin
        if (cap_tx[0][4*b+k] !== exp_f[b]) begin bad = 1'b1; got = cap_tx[0][4*b+k]; end
      end
      checks++; if (bad) begin failures++; $display("FAIL a5_bit%0d got=%b exp=%b", b, got, exp_f[b]); end
    end
    bad = 1'b0;
    for (int i = 0; i < 40; i++) if (cap_busy[0][i] !== 1'b1) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL a5_busy_40 got=dropped exp=high_40_cycles"); end
    checks++; if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL a5_end tx=%b busy=%b exp=1/0", tx[0], busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_f;
    logic ok, bad, got;
    int acc0;
    exp_f = {10'b1_11111111_0, 10'b1_00000000_0};  // 0x00 frame then 0xFF frame
    tick_per = 4;
    acc0 = acc_cnt[0];
    data = 8'h00; valid[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      next_cyc();
      if (acc_cnt[0] == acc0 + 1) data = 8'hFF;
      if (tx[0] === 1'b0) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL b2b_start_timeout got=none exp=start"); end
    for (int i = 0; i < 80; i++) begin
      for (int w = 0; w < 4; w++) begin cap_tx[w][i] = tx[w]; cap_busy[w][i] = busy[w]; end
      if (acc_cnt[0] >= acc0 + 2) valid[0] = 1'b0;
      next_cyc();
    end
    valid[0] = 1'b0;
    for (int b = 0; b < 20; b++) begin
      bad = 1'b0; got = exp_f[b];
      for (int k = 0; k < 4; k++) begin
        if (cap_tx[0][4*b+k] !== exp_f[b]) begin bad = 1'b1; got = cap_tx[0][4*b+k]; end
      end
      checks++; if (bad) begin failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", b, got, exp_f[b]); end
    end
    bad = 1'b0;
    for (int i = 0; i < 80; i++) if (cap_busy[0][i] !== 1'b1) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL b2b_busy_gap got=dropped exp=high_80_cycles"); end
    checks++; if (acc_cnt[0] - acc0 !== 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", acc_cnt[0] - acc0); end
    checks++; if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_end tx=%b busy=%b exp=1/0", tx[0], busy[0]);
    end
  endtask

  task automatic test_parity();
    logic [10:0] exp_e, exp_o;
    logic ok;
    exp_e = 11'b1_1_00000111_0;  // even parity of 0x07 = 1
    exp_o = 11'b1_0_00000111_0;  // odd parity of 0x07 = 0
    tick_per = 2;
    data = 8'h07; valid = 4'b0110;
    next_cyc();
    valid = 4'b0000;
    wait_start(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL par_start_timeout got=none exp=start"); end
    capture(22);
    for (int b = 0; b < 11; b++) begin
      checks++;
      if (cap_tx[1][2*b] !== exp_e[b] || cap_tx[1][2*b+1] !== exp_e[b]) begin
        failures++; $display("FAIL even_bit%0d got=%b%b exp=%b", b, cap_tx[1][2*b], cap_tx[1][2*b+1], exp_e[b]);
      end
      checks++;
      if (cap_tx[2][2*b] !== exp_o[b] || cap_tx[2][2*b+1] !== exp_o[b]) begin
        failures++; $display("FAIL odd_bit%0d got=%b%b exp=%b", b, cap_tx[2][2*b], cap_tx[2][2*b+1], exp_o[b]);
      end
    end
    checks++; if (cap_busy[1][21] !== 1'b1 || cap_busy[2][21] !== 1'b1) begin
      failures++; $display("FAIL par_busy_len got=%b%b exp=11", cap_busy[1][21], cap_busy[2][21]);
    end
    checks++; if (busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
      failures++; $display("FAIL par_busy_end got=%b%b exp=00", busy[1], busy[2]);
    end
  endtask

  task automatic test_tick_every_cycle();
    logic [9:0]  exp_a;
    logic [10:0] exp_b;
    exp_a = 10'b1_00111100_0;   // 0x3C, 1 stop
    exp_b = 11'b11_00111100_0;  // 0x3C, 2 stops
    tick_per = 1; tick = 1'b1;
    data = 8'h3C; valid = 4'b1001;
    next_cyc();
    valid = 4'b0000;
    checks++; if (tx[0] !== 1'b1 || ready[0] !== 1'b0) begin
      failures++; $display("FAIL idle_tick_accept tx=%b ready=%b exp=1/0", tx[0], ready[0]);
    end
    next_cyc();
    capture(11);
    for (int b = 0; b < 10; b++) begin
      checks++; if (cap_tx[0][b] !== exp_a[b]) begin
        failures++; $display("FAIL tick1_n1_bit%0d got=%b exp=%b", b, cap_tx[0][b], exp_a[b]);
      end
    end
    for (int b = 0; b < 11; b++) begin
      checks++; if (cap_tx[3][b] !== exp_b[b]) begin
        failures++; $display("FAIL tick1_n2_bit%0d got=%b exp=%b", b, cap_tx[3][b], exp_b[b]);
      end
    end
    checks++; if (cap_busy[0][9] !== 1'b1 || cap_busy[0][10] !== 1'b0) begin
      failures++; $display("FAIL tick1_n1_len got=%b%b exp=10", cap_busy[0][9], cap_busy[0][10]);
    end
    checks++; if (cap_busy[3][10] !== 1'b1 || busy[3] !== 1'b0) begin
      failures++; $display("FAIL tick1_n2_len got=%b%b exp=10", cap_busy[3][10], busy[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp_f;
    logic ok, bad;
    exp_f = 10'b1_10000001_0;  // 0x81
    tick_per = 4;
    data = 8'h52; valid[0] = 1'b1;
    next_cyc();
    valid[0] = 1'b0;
    wait_start(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_start_timeout got=none exp=start"); end
    data = 8'h33; valid[0] = 1'b1;
    next_cyc();
    valid[0] = 1'b0;
    checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL mid_held got=%b exp=0", ready[0]); end
    for (int i = 0; i < 16; i++) next_cyc();
    checks++; if (tx[0] !== 1'b0) begin failures++; $display("FAIL mid_bit3 got=%b exp=0", tx[0]); end
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    checks++; if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL mid_rst tx=%b ready=%b busy=%b exp=1/1/0", tx[0], ready[0], busy[0]);
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL mid_discard got=activity exp=idle"); end
    data = 8'h81; valid[0] = 1'b1;
    next_cyc();
    valid[0] = 1'b0;
    wait_start(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid81_start_timeout got=none exp=start"); end
    capture(40);
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (cap_tx[0][4*b] !== exp_f[b] || cap_tx[0][4*b+3] !== exp_f[b]) begin
        failures++; $display("FAIL mid81_bit%0d got=%b%b exp=%b", b, cap_tx[0][4*b], cap_tx[0][4*b+3], exp_f[b]);
      end
    end
    checks++; if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL mid81_end tx=%b busy=%b exp=1/0", tx[0], busy[0]);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; valid = 4'h0; data = 8'h00;
    for (int w = 0; w < 4; w++) acc_cnt[w] = 0;
    test_reset();
    test_frame_8n1();
    test_back_to_back();
    test_parity();
    test_tick_every_cycle();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Asynchronous serial transmitter that consumes the 1-cycle baud strobe produced by the pulse divider. Each strobe is one bit time.
- Takes parallel words over a valid/ready handshake and serialises them LSB-first as start / data / optional parity / stop frames on a single line.
- A one-entry holding register lets the next word queue behind the word in flight, so frames go back-to-back with no idle bit between them.

Parameters:
- data_bits, 8, data bits per frame; legal 5..9.
- stop_bits, 1, stop bits per frame; legal 1 or 2.
- parity, 0, 0 = none, 1 = odd, 2 = even.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_tick  in  1  baud strobe, one-cycle pulse per bit time. Any spacing ≥1 cycle is legal, including every cycle.
- i_data  in  data_bits  word to send; sampled on accept.
- i_valid  in  1  i_data valid.
- o_ready  out  1  holding register empty; accept occurs when i_valid && o_ready at a rising edge.
- o_tx  out  1  serial line, idle high; registered.
- o_busy  out  1  frame in progress (shifter not idle); registered.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
  - Reset values: o_tx=1, o_ready=1, o_busy=0, holding register empty, shifter state IDLE, bit counter 0.
  - i_rst has priority over i_tick and over accept in the same cycle.
- Holding register:
  - On accept, latch i_data and set hold_full; o_ready = !hold_full.
  - While hold_full, i_valid is ignored and i_data may change freely.
- Shifter states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on cycles with i_tick=1.
  - IDLE, tick, hold_full: move to START, o_tx←0, move the word to the shift register, clear hold_full (o_ready=1 next cycle), o_busy←1.
  - IDLE, tick, hold empty: nothing happens; o_tx stays 1.
  - START, tick: move to DATA, o_tx←data bit 0.
  - DATA, tick: o_tx←next bit, LSB first. After data_bits bits, go to PARITY if parity≠0, else to STOP.
  - PARITY bit value: even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: o_tx=1 for stop_bits ticks.
  - Tick ending the last stop bit, hold_full: go straight to START with o_tx←0 (zero-gap back-to-back frames).
  - Tick ending the last stop bit, hold empty: go to IDLE, o_busy←0, o_tx stays 1.
- Timing:
  - o_tx changes in the cycle after the edge where i_tick is sampled high.
  - Every line bit lasts exactly one tick interval.
  - Frame = 1 + data_bits + (parity≠0) + stop_bits ticks.
- Accept in the same cycle as an IDLE tick with hold empty: the word is stored; the frame starts on the following tick, not this one.
- Accept in the same cycle as a tick that drains the holding register: cannot occur, since o_ready=0 while hold_full.
- Back-to-back ticks (i_tick continuously 1): one bit per clock, no dropped or duplicated bits.
- Reset mid-frame: o_tx returns to 1 at the next edge. The in-flight word and the held word are discarded, o_ready=1, o_busy=0. A truncated frame on the line is acceptable.
- Parameter legality: illegal parameter values are a design error; assert in simulation.

Test Plan:
1. Assert i_rst 3 cycles with i_valid=1 and ticks running → o_tx=1, o_ready=1, o_busy=0 throughout; nothing transmitted.
2. 8N1, tick every 4 clocks, send 0xA5 → starting after the first tick following accept, o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. o_busy high for 40 cycles. o_ready back to 1 one cycle after the start-bit tick.
3. Hold i_valid high with 0x00 then 0xFF → second start bit immediately follows the first stop bit (no extra 1 bit). Two accepts observed. o_busy never drops between frames.
4. parity=2, send 0x07 → parity bit 1. parity=1, send 0x07 → parity bit 0. Frame length 11 ticks.
5. i_tick tied high, 8N1, send 0x3C → 10-cycle frame 0,0,0,1,1,1,1,0,0,1. stop_bits=2 variant → 11 cycles with two trailing 1s.
6. Assert i_rst during data bit 3 with a second word held → o_tx=1 next cycle, o_ready=1, o_busy=0. After release, a new word 0x81 transmits correctly and the discarded word never appears.
